// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display counter path.
// Digit width and per-mode digit ceilings live here.
package hex_disp_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'h9;

    function automatic logic [DIGIT_W-1:0] digit_max(input bit bcd_mode);
        return bcd_mode ? BCD_MAX : HEX_MAX;
    endfunction

endpackage

// File: rtl/hex_digit_counter_digit_cell.sv
// One 4-bit up/down digit with load and carry/borrow chaining.
// adv_out fires when this digit rolls over while advancing.
module digit_cell
    import hex_disp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    input  logic               adv_in,
    input  logic               up,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] d,
    output logic               adv_out
);

    logic at_limit;

    // >= lets an out-of-range loaded digit fall back to 0 going up
    assign at_limit = up ? (d >= max) : (d == '0);
    assign adv_out  = adv_in & at_limit;

    // digit register: load beats advance, advance beats hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d <= '0;
        end else if (load) begin
            d <= load_d;
        end else if (adv_in) begin
            if (up) begin
                d <= at_limit ? '0 : d + 4'd1;
            end else begin
                d <= at_limit ? max : d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/hex_digit_counter.sv
// Multi-digit up/down counter feeding the 7-segment decoders.
// Advances on a prescaled tick or a debounced-edge manual step.
module hex_digit_counter
    import hex_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000,
    parameter bit BCD_MODE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      step,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] digits,
    output logic                      tick,
    output logic                      wrap_o
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DIGIT_W-1:0] MAX = digit_max(BCD_MODE);

    logic [PW-1:0]   pre;
    logic            s1;
    logic            s2;
    logic            s3;
    logic            step_evt;
    logic            advance;
    logic [DIGITS:0] adv;

    // prescaler freezes with en low; tick is registered at terminal count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= en && (pre == PRE_LAST);
            if (en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
            end
        end
    end

    // two-flop synchroniser plus one flop for rising-edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_evt = s2 & ~s3;
    assign advance  = tick | step_evt;
    assign adv[0]   = advance;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .load_d  (load_val[i*DIGIT_W +: DIGIT_W]),
            .adv_in  (adv[i]),
            .up      (up),
            .max     (MAX),
            .d       (digits[i*DIGIT_W +: DIGIT_W]),
            .adv_out (adv[i+1])
        );
    end

    // whole-count wrap, suppressed when a load overrides the advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_o <= 1'b0;
        end else begin
            wrap_o <= !load && adv[DIGITS];
        end
    end

endmodule
